// File: rtl/game_motion_engine_if.sv
// Data-RAM write port shared with the CPU arbiter.
// The engine holds ram_we until the arbiter answers with wr_ack in the same cycle.
interface game_motion_engine_if;
    logic [15:0] ram_addr;
    logic [15:0] ram_d;
    logic        ram_we;
    logic        wr_ack;

    modport master (output ram_addr, ram_d, ram_we, input wr_ack);
    modport slave  (input ram_addr, ram_d, ram_we, output wr_ack);
endinterface

// File: rtl/game_motion_engine.sv
// Per-frame game-state updater: jump physics, obstacle scroll/wrap and score.
// Results are written to data RAM over a req/ack port, followed by a collision check.
module game_motion_engine #(
    parameter logic [15:0] POS_BASE  = 16'h100,
    parameter int          GROUND_Y  = 200,
    parameter int          JUMP_V    = 12,
    parameter int          GRAVITY   = 1,
    parameter int          OBS_START = 640,
    parameter int          OBS_SPEED = 4,
    parameter int          PLAYER_X  = 64,
    parameter int          SPR_W     = 64,
    parameter int          SPR_H     = 64
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic                 jump_btn,
    input  logic                 restart,
    game_motion_engine_if.master ram,
    output logic                 game_over,
    output logic                 busy,
    output logic                 frame_overrun
);

    typedef enum logic [2:0] {IDLE, COMPUTE, WR_Y, WR_X, WR_S, CHECK, OVER} state_t;

    localparam logic [15:0]        GROUND_U = 16'(GROUND_Y);
    localparam logic [15:0]        OBS_ST_U = 16'(OBS_START);
    localparam logic [15:0]        OBS_SP_U = 16'(OBS_SPEED);
    localparam logic signed [16:0] GROUND_S = 17'(GROUND_Y);
    localparam logic signed [16:0] JUMP_S   = 17'(JUMP_V);
    localparam logic signed [16:0] GRAV_S   = 17'(GRAVITY);
    localparam logic [16:0]        HIT_XR   = 17'(PLAYER_X + SPR_W);
    localparam logic [16:0]        HIT_XL   = 17'(PLAYER_X);
    localparam logic [16:0]        HIT_Y    = 17'(GROUND_Y);
    localparam logic [16:0]        SPR_W17  = 17'(SPR_W);
    localparam logic [16:0]        SPR_H17  = 17'(SPR_H);

    state_t             state, state_nxt;
    logic [15:0]        player_y, obstacle_x, score;
    logic signed [7:0]  vel;
    logic               jump_pending;
    logic               sync1, sync2, sync_prev;
    logic               jump_edge;
    logic signed [16:0] vel_ext, v_eff, y_new, vel_nxt;
    logic               hit;

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= jump_btn;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign jump_edge = sync2 & ~sync_prev;

    always_comb begin
        vel_ext = {{9{vel[7]}}, vel};
        v_eff   = (player_y == GROUND_U && jump_pending) ? -JUMP_S : vel_ext;
        y_new   = $signed({1'b0, player_y}) + v_eff;
        vel_nxt = v_eff + GRAV_S;
        hit     = ({1'b0, obstacle_x} < HIT_XR)
               && (({1'b0, obstacle_x} + SPR_W17) > HIT_XL)
               && (({1'b0, player_y} + SPR_H17) > HIT_Y);
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start) state_nxt = COMPUTE;
            COMPUTE: state_nxt = WR_Y;
            WR_Y:    if (ram.wr_ack) state_nxt = WR_X;
            WR_X:    if (ram.wr_ack) state_nxt = WR_S;
            WR_S:    if (ram.wr_ack) state_nxt = CHECK;
            CHECK:   state_nxt = hit ? OVER : IDLE;
            OVER:    if (restart) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Write port is decoded from state, so an async reset drops ram_we immediately.
    always_comb begin
        ram.ram_we   = 1'b0;
        ram.ram_addr = POS_BASE;
        ram.ram_d    = '0;
        busy         = !(state == IDLE || state == OVER);
        game_over    = (state == OVER);
        case (state)
            WR_Y: begin
                ram.ram_we = 1'b1;
                ram.ram_d  = player_y;
            end
            WR_X: begin
                ram.ram_we   = 1'b1;
                ram.ram_addr = POS_BASE + 16'd1;
                ram.ram_d    = obstacle_x;
            end
            WR_S: begin
                ram.ram_we   = 1'b1;
                ram.ram_addr = POS_BASE + 16'd2;
                ram.ram_d    = score;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            player_y      <= GROUND_U;
            vel           <= '0;
            obstacle_x    <= OBS_ST_U;
            score         <= '0;
            jump_pending  <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            if (jump_edge)
                jump_pending <= 1'b1;
            if (frame_start && busy)
                frame_overrun <= 1'b1;
            case (state)
                COMPUTE: begin
                    // A pending jump is used or discarded here, never carried over.
                    jump_pending <= 1'b0;
                    if (y_new >= GROUND_S) begin
                        player_y <= GROUND_U;
                        vel      <= '0;
                    end else if (y_new < 17'sd0) begin
                        player_y <= '0;
                        vel      <= '0;
                    end else begin
                        player_y <= y_new[15:0];
                        vel      <= vel_nxt[7:0];
                    end
                    if (obstacle_x < OBS_SP_U) begin
                        obstacle_x <= OBS_ST_U;
                        if (score != '1)
                            score <= score + 16'd1;
                    end else begin
                        obstacle_x <= obstacle_x - OBS_SP_U;
                    end
                end
                OVER: begin
                    if (restart) begin
                        player_y      <= GROUND_U;
                        vel           <= '0;
                        obstacle_x    <= OBS_ST_U;
                        score         <= '0;
                        jump_pending  <= 1'b0;
                        frame_overrun <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_motion_engine.sv
// Randomized scoreboard bench for game_motion_engine against a frame-level game model.
// A second instance with the player moved off-screen exercises the obstacle wrap and score.
module tb_game_motion_engine;

    localparam int GROUND_Y  = 200;
    localparam int JUMP_V    = 12;
    localparam int GRAVITY   = 1;
    localparam int OBS_START = 640;
    localparam int OBS_SPEED = 4;
    localparam int PLAYER_X  = 64;
    localparam int SPR_W     = 64;
    localparam int SPR_H     = 64;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    logic sys_clk = 1'b0;
    logic reset = 1'b0;
    logic frame_start = 1'b0;
    logic jump_btn = 1'b0;
    logic restart = 1'b0;
    logic game_over, busy, frame_overrun;
    logic fs2 = 1'b0;
    logic go2, busy2, ovr2;

    game_motion_engine_if bus ();
    game_motion_engine_if bus2 ();

    assign bus2.wr_ack = 1'b1;

    game_motion_engine dut (
        .sys_clk       (sys_clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .jump_btn      (jump_btn),
        .restart       (restart),
        .ram           (bus),
        .game_over     (game_over),
        .busy          (busy),
        .frame_overrun (frame_overrun)
    );

    game_motion_engine #(.PLAYER_X(700)) dut_wrap (
        .sys_clk       (sys_clk),
        .reset         (reset),
        .frame_start   (fs2),
        .jump_btn      (1'b0),
        .restart       (1'b0),
        .ram           (bus2),
        .game_over     (go2),
        .busy          (busy2),
        .frame_overrun (ovr2)
    );

    always #10 sys_clk = ~sys_clk;

    int  tests = 0;
    int  fails = 0;
    wr_t exp_q[$];
    int  m_py, m_vel, m_ox, m_score;
    bit  m_jp, m_over, m_ovr;
    logic [15:0] x2 = '0;
    logic [15:0] s2 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic void model_init();
        m_py = GROUND_Y; m_vel = 0; m_ox = OBS_START; m_score = 0;
        m_jp = 0; m_over = 0; m_ovr = 0;
    endfunction

    function automatic void model_frame();
        int v_eff, y;
        v_eff = (m_py == GROUND_Y && m_jp) ? -JUMP_V : m_vel;
        y = m_py + v_eff;
        if (y >= GROUND_Y) begin
            m_py = GROUND_Y; m_vel = 0;
        end else if (y < 0) begin
            m_py = 0; m_vel = 0;
        end else begin
            m_py = y; m_vel = v_eff + GRAVITY;
        end
        m_jp = 0;
        if (m_ox < OBS_SPEED) begin
            m_ox = OBS_START;
            if (m_score < 65535) m_score++;
        end else begin
            m_ox -= OBS_SPEED;
        end
        exp_q.push_back('{16'h100, 16'(m_py)});
        exp_q.push_back('{16'h101, 16'(m_ox)});
        exp_q.push_back('{16'h102, 16'(m_score)});
        m_over = (m_ox < PLAYER_X + SPR_W) && (m_ox + SPR_W > PLAYER_X) && (m_py + SPR_H > GROUND_Y);
    endfunction

    // Every cycle with a write request is held against the head of the expected queue.
    always @(negedge sys_clk) begin
        if (reset && bus.ram_we) begin
            if (exp_q.size() == 0) begin
                chk("spurious_write", 32'(bus.ram_addr), 32'hFFFF_FFFF);
            end else begin
                chk("wr_addr", 32'(bus.ram_addr), 32'(exp_q[0].a));
                chk("wr_data", 32'(bus.ram_d), 32'(exp_q[0].d));
                if (bus.wr_ack) void'(exp_q.pop_front());
            end
        end
    end

    always @(negedge sys_clk) begin
        if (reset && bus2.ram_we) begin
            if (bus2.ram_addr == 16'h101) x2 <= bus2.ram_d;
            if (bus2.ram_addr == 16'h102) s2 <= bus2.ram_d;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_frame(input int st0, input int st1, input int st2, input bit ovr);
        int st[3];
        st = '{st0, st1, st2};
        model_frame();
        if (ovr) m_ovr = 1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        bus.wr_ack = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c <= st[i]; c++) begin
                bus.wr_ack = (c == st[i]);
                if (ovr && i == 0 && c == 0) frame_start = 1'b1;
                tick();
                frame_start = 1'b0;
            end
        end
        bus.wr_ack = 1'b0;
        chk("busy_in_check", 32'(busy), 32'd1);
        tick();
        chk("busy_after_frame", 32'(busy), 32'd0);
        chk("game_over", 32'(game_over), 32'(m_over));
        chk("frame_overrun", 32'(frame_overrun), 32'(m_ovr));
        chk("writes_drained", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    task automatic press_jump();
        jump_btn = 1'b1;
        repeat (3) tick();
        jump_btn = 1'b0;
        repeat (4) tick();
        m_jp = 1;
    endtask

    task automatic over_seq(input bit try_fs);
        if (try_fs) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            repeat (8) tick();
            chk("over_holds", 32'(game_over), 32'd1);
            chk("over_no_overrun", 32'(frame_overrun), 32'(m_ovr));
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        model_init();
        chk("restart_go", 32'(game_over), 32'd0);
        chk("restart_busy", 32'(busy), 32'd0);
        chk("restart_overrun", 32'(frame_overrun), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_we"}, 32'(bus.ram_we), 32'd0);
        chk({tag, "_addr"}, 32'(bus.ram_addr), 32'h100);
        chk({tag, "_data"}, 32'(bus.ram_d), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_go"}, 32'(game_over), 32'd0);
        chk({tag, "_ovr"}, 32'(frame_overrun), 32'd0);
    endtask

    initial begin
        bus.wr_ack = 1'b0;
        model_init();
        repeat (3) tick();
        check_reset_values("reset");
        reset = 1'b1;
        tick();

        do_frame(0, 0, 0, 0);
        do_frame(0, 5, 0, 0);
        press_jump();
        do_frame(0, 0, 0, 0);
        do_frame(1, 0, 2, 0);
        press_jump();
        do_frame(0, 0, 0, 0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_ignored_go", 32'(game_over), 32'd0);
        chk("restart_ignored_busy", 32'(busy), 32'd0);

        for (int f = 0; f < 400; f++) begin
            if (m_over) begin
                over_seq(1'($urandom_range(0, 1)));
            end else begin
                if ($urandom_range(0, 3) == 0) press_jump();
                if ($urandom_range(0, 9) == 0) begin
                    restart = 1'b1;
                    tick();
                    restart = 1'b0;
                end
                do_frame($urandom_range(0, 1) ? 0 : int'($urandom_range(1, 4)),
                         $urandom_range(0, 1) ? 0 : int'($urandom_range(1, 4)),
                         $urandom_range(0, 1) ? 0 : int'($urandom_range(1, 4)),
                         1'($urandom_range(0, 9) == 0));
            end
        end

        if (m_over) over_seq(0);
        do_frame(0, 0, 0, 1);
        model_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        bus.wr_ack = 1'b0;
        tick();
        chk("wr_y_stalled_we", 32'(bus.ram_we), 32'd1);
        reset = 1'b0;
        #1;
        check_reset_values("midframe_reset");
        exp_q.delete();
        model_init();
        tick();
        reset = 1'b1;
        tick();
        do_frame(0, 0, 0, 0);

        for (int f = 1; f <= 161; f++) begin
            fs2 = 1'b1;
            tick();
            fs2 = 1'b0;
            repeat (7) tick();
            if (f == 1) chk("wrap_first_x", 32'(x2), 32'd636);
            if (f == 160) begin
                chk("wrap_x_zero", 32'(x2), 32'd0);
                chk("wrap_score_zero", 32'(s2), 32'd0);
                chk("wrap_no_hit", 32'(go2), 32'd0);
            end
        end
        chk("wrap_x_restart", 32'(x2), 32'd640);
        chk("wrap_score_one", 32'(s2), 32'd1);
        chk("wrap_hit_at_start", 32'(go2), 32'd1);
        chk("wrap_busy", 32'(busy2), 32'd0);
        chk("wrap_overrun", 32'(ovr2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
